// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: state encoding,
// opcode values and instruction-register field positions.
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T0   = 3'd1,
      S_T1   = 3'd2,
      S_T2   = 3'd3,
      S_T3   = 3'd4,
      S_T4   = 3'd5,
      S_T5   = 3'd6,
      S_HALT = 3'd7
   } state_t;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b01001;
   localparam logic [4:0] OP_OR   = 5'b01010;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam int OP_MSB = 31;
   localparam int OP_LSB = 27;
   localparam int RA_MSB = 26;
   localparam int RA_LSB = 23;
   localparam int RB_MSB = 22;
   localparam int RB_LSB = 19;
   localparam int RC_MSB = 18;
   localparam int RC_LSB = 15;

   function automatic logic is_alu(input logic [4:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
   endfunction

endpackage

// File: rtl/reg_decoder.sv
// 4-bit register index to 16-bit one-hot select; all zeros when disabled.
module reg_decoder (
   input  logic [3:0]  index,
   input  logic        en,
   output logic [15:0] one_hot
);

   always_comb begin
      one_hot = '0;
      if (en) one_hot[index] = 1'b1;
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control sequencer for a single-bus datapath.
// Define CTRL_MEM_WAIT_EN to stretch T1 until MemRdy reports the read done.
module control_sequencer
   import cpu_ctrl_pkg::*;
(
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Start,
   input  logic        Stop,
   input  logic        MemRdy,
   input  logic [31:0] IR,
   input  logic        CountLoad,
   input  logic [15:0] CountPreset,
   output logic        PCout,
   output logic        Zlowout,
   output logic        MDRout,
   output logic        MARin,
   output logic        Zin,
   output logic        PCin,
   output logic        MDRin,
   output logic        IRin,
   output logic        Yin,
   output logic        IncPC,
   output logic        Read,
   output logic        ADD,
   output logic        SUB,
   output logic        AND,
   output logic        OR,
   output logic        Run,
   output logic        Err,
   output logic [15:0] Rout,
   output logic [15:0] Rin,
   output logic [15:0] InstrCount,
   output state_t      DbgState
);

   state_t      state;
   logic        stop_pend;
   logic        err_q;
   logic [15:0] instr_count;

   logic [4:0]  opcode;
   logic [3:0]  ra, rb, rc;
   logic        alu_op, legal_op, active, t1_done, halt_req, retire, enter_halt;
   logic [3:0]  rout_idx;
   logic        rout_en, rin_en;
   logic        unused_ir;

   assign opcode    = IR[OP_MSB:OP_LSB];
   assign ra        = IR[RA_MSB:RA_LSB];
   assign rb        = IR[RB_MSB:RB_LSB];
   assign rc        = IR[RC_MSB:RC_LSB];
   assign unused_ir = ^IR[RC_LSB-1:0];

   assign alu_op   = is_alu(opcode);
   assign legal_op = alu_op || (opcode == OP_NOP) || (opcode == OP_HALT);
   assign active   = (state != S_IDLE) && (state != S_HALT);

`ifdef CTRL_MEM_WAIT_EN
   assign t1_done = MemRdy;
`else
   logic unused_mem_rdy;
   assign unused_mem_rdy = MemRdy;
   assign t1_done        = 1'b1;
`endif

   // A Stop seen in the retiring cycle itself counts as pending too.
   assign halt_req   = stop_pend | Stop;
   assign retire     = (state == S_T5) || ((state == S_T3) && !alu_op);
   assign enter_halt = ((state == S_T3) && !alu_op && ((opcode == OP_HALT) || halt_req)) ||
                       ((state == S_T5) && halt_req);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state       <= S_IDLE;
         stop_pend   <= 1'b0;
         err_q       <= 1'b0;
         instr_count <= 16'h0000;
      end else begin
         case (state)
            S_IDLE, S_HALT: if (Start) state <= S_T0;
            S_T0: state <= S_T1;
            S_T1: if (t1_done) state <= S_T2;
            S_T2: state <= S_T3;
            S_T3: begin
               if (alu_op)          state <= S_T4;
               else if (enter_halt) state <= S_HALT;
               else                 state <= S_T0;
            end
            S_T4: state <= S_T5;
            S_T5: state <= enter_halt ? S_HALT : S_T0;
            default: state <= S_IDLE;
         endcase

         if (enter_halt)           stop_pend <= 1'b0;
         else if (active && Stop)  stop_pend <= 1'b1;

         if ((state == S_T3) && !legal_op) err_q <= 1'b1;

         if (CountLoad)   instr_count <= CountPreset;
         else if (retire) instr_count <= instr_count + 16'd1;
      end
   end

   // Rb is driven in T3 and Rc in T4 through the same decoder.
   assign rout_idx = (state == S_T4) ? rc : rb;
   assign rout_en  = ((state == S_T3) && alu_op) || (state == S_T4);
   assign rin_en   = (state == S_T5);

   reg_decoder u_rout_dec (.index(rout_idx), .en(rout_en), .one_hot(Rout));
   reg_decoder u_rin_dec  (.index(ra),       .en(rin_en),  .one_hot(Rin));

   always_comb begin
      PCout   = 1'b0;
      Zlowout = 1'b0;
      MDRout  = 1'b0;
      MARin   = 1'b0;
      Zin     = 1'b0;
      PCin    = 1'b0;
      MDRin   = 1'b0;
      IRin    = 1'b0;
      Yin     = 1'b0;
      IncPC   = 1'b0;
      Read    = 1'b0;
      ADD     = 1'b0;
      SUB     = 1'b0;
      AND     = 1'b0;
      OR      = 1'b0;
      case (state)
         S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
         S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
         S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
         S_T3: Yin = alu_op;
         S_T4: begin
            Zin = 1'b1;
            ADD = (opcode == OP_ADD);
            SUB = (opcode == OP_SUB);
            AND = (opcode == OP_AND);
            OR  = (opcode == OP_OR);
         end
         S_T5: Zlowout = 1'b1;
         default: ;
      endcase
   end

   assign Run        = active;
   assign Err        = err_q;
   assign InstrCount = instr_count;
   assign DbgState   = state;

endmodule
